// File: rtl/conv_2d_coef_loader_pkg.sv
// Shared types and sizing helpers for the conv_2d coefficient loader.
package conv_2d_coef_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EOF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } loader_state_t;

  // Number of coefficients in a square kernel of the given side.
  function automatic int coef_amount(input int win_size);
    return win_size * win_size;
  endfunction

  localparam int WIN_SIZE_DEF    = 3;
  localparam int COEF_AMOUNT_DEF = coef_amount(WIN_SIZE_DEF);
  localparam int COEF_NUM_WIDTH  = $clog2(COEF_AMOUNT_DEF);
  // Coefficient width on the bridge side; loader values are sign-extended to it.
  localparam int IF_COEF_WIDTH   = 16;

endpackage

// File: rtl/conv_2d_if.sv
// Coefficient write port of the conv_2d bridge: one write per strobed cycle.
interface conv_2d_if
  import conv_2d_coef_loader_pkg::*;
#(
  parameter int NUM_W = COEF_NUM_WIDTH,
  parameter int VAL_W = IF_COEF_WIDTH
);
  logic             wr_stb;
  logic [NUM_W-1:0] coef_num;
  logic [VAL_W-1:0] coef_val;

  modport master (output wr_stb, output coef_num, output coef_val);
  modport slave  (input  wr_stb, input  coef_num, input  coef_val);
endinterface

// File: rtl/conv_2d_coef_mirror.sv
// Write-back mirror of the bridge coefficient registers. It reports whether a
// candidate value equals the stored one and records every value actually written.
module conv_2d_coef_mirror #(
  parameter int COEF_WIDTH  = 13,
  parameter int COEF_AMOUNT = 9,
  parameter int IDX_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [COEF_WIDTH-1:0] val_i,
  input  logic                  upd_i,
  output logic                  equal_o
);

  logic [COEF_WIDTH-1:0] r_mirror [COEF_AMOUNT];

  // Clear with the bridge on reset, then track each issued coefficient write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < COEF_AMOUNT; i++) begin
        r_mirror[i] <= {COEF_WIDTH{1'b0}};
      end
    end else if (upd_i) begin
      r_mirror[idx_i] <= val_i;
    end
  end

  assign equal_o = (r_mirror[idx_i] == val_i);

endmodule

// File: rtl/conv_2d_coef_loader.sv
// Serialises a full kernel into single-cycle coefficient writes on conv_2d_if,
// optionally deferred to end of frame, skipping writes the bridge already holds.
module conv_2d_coef_loader
  import conv_2d_coef_loader_pkg::*;
#(
  parameter int  COEF_WIDTH     = 13,
  parameter int  WIN_SIZE       = 3,
  parameter int  FRAME_SYNC_EN  = 1,
  parameter int  SKIP_UNCHANGED = 1,
  localparam int COEF_AMOUNT    = coef_amount(WIN_SIZE)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [COEF_AMOUNT*COEF_WIDTH-1:0] req_kernel_i,
  input  logic                              req_sync_i,
  input  logic                              eof_stb_i,
  conv_2d_if.master                         conv_2d_ctrl_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int IDX_W = $clog2(COEF_AMOUNT);
  localparam int VAL_W = IF_COEF_WIDTH;

  // Two's complement widening of a kernel coefficient to the bridge width.
  function automatic logic [VAL_W-1:0] sext_coef(input logic [COEF_WIDTH-1:0] v);
    return {{(VAL_W-COEF_WIDTH){v[COEF_WIDTH-1]}}, v};
  endfunction

  loader_state_t         r_state;
  logic [COEF_WIDTH-1:0] r_shadow [COEF_AMOUNT];
  logic                  r_sync;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_coef_val;
  logic                  r_wr_stb;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_sync_eff;
  logic                  w_last;
  logic                  w_present;
  logic                  w_issue;
  logic                  w_equal;
  logic [IDX_W-1:0]      w_next_idx;
  logic [COEF_WIDTH-1:0] w_next_val;

  assign w_accept   = req_valid_i && r_ready;
  assign w_sync_eff = (FRAME_SYNC_EN != 0) && req_sync_i;
  assign w_last     = (r_idx == IDX_W'(COEF_AMOUNT-1));
  assign w_issue    = w_present && ((SKIP_UNCHANGED == 0) || !w_equal);

  // Select the coefficient to present next cycle. On the first index the value
  // comes straight from the request (IDLE) or from the shadow (WAIT_EOF), so the
  // registered outputs show index 0 the cycle after the FSM leaves those states.
  always_comb begin
    w_next_idx = {IDX_W{1'b0}};
    w_next_val = r_shadow[0];
    w_present  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_val = req_kernel_i[COEF_WIDTH-1:0];
        w_present  = w_accept && !w_sync_eff;
      end
      ST_WAIT_EOF: begin
        w_present = eof_stb_i || !r_sync;
      end
      ST_WRITE: begin
        if (w_last) begin
          w_present = 1'b0;
        end else begin
          w_next_idx = r_idx + IDX_W'(1);
          w_next_val = r_shadow[w_next_idx];
          w_present  = 1'b1;
        end
      end
      default: begin
        w_present = 1'b0;
      end
    endcase
  end

  conv_2d_coef_mirror #(
    .COEF_WIDTH  (COEF_WIDTH),
    .COEF_AMOUNT (COEF_AMOUNT),
    .IDX_W       (IDX_W)
  ) u_mirror (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx_i   (w_next_idx),
    .val_i   (w_next_val),
    .upd_i   (w_issue),
    .equal_o (w_equal)
  );

  // Loader FSM with the index counter, shadow kernel and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_sync     <= 1'b0;
      r_idx      <= {IDX_W{1'b0}};
      r_coef_val <= {VAL_W{1'b0}};
      r_wr_stb   <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < COEF_AMOUNT; i++) begin
        r_shadow[i] <= {COEF_WIDTH{1'b0}};
      end
    end else begin
      r_wr_stb <= 1'b0;
      r_done   <= 1'b0;
      if (w_present) begin
        r_idx      <= w_next_idx;
        r_coef_val <= sext_coef(w_next_val);
        r_wr_stb   <= w_issue;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < COEF_AMOUNT; i++) begin
              r_shadow[i] <= req_kernel_i[i*COEF_WIDTH +: COEF_WIDTH];
            end
            r_sync  <= w_sync_eff;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= w_sync_eff ? ST_WAIT_EOF : ST_WRITE;
          end
        end
        ST_WAIT_EOF: begin
          if (w_present) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign conv_2d_ctrl_o.wr_stb   = r_wr_stb;
  assign conv_2d_ctrl_o.coef_num = r_idx;
  assign conv_2d_ctrl_o.coef_val = r_coef_val;
  assign req_ready_o             = r_ready;
  assign busy_o                  = r_busy;
  assign done_o                  = r_done;

endmodule

// File: doc/conv_2d_coef_loader.md
# conv_2d_coef_loader

Master-side driver of the conv_2d coefficient write interface: accepts a complete WIN_SIZE×WIN_SIZE kernel through a valid/ready request port and serialises it into single-cycle coefficient writes on `conv_2d_if`. It feeds the coefficient bridge in front of `conv_2d`. Updates can be deferred to an end-of-frame strobe so a kernel never changes mid-frame. A write-back mirror suppresses strobes for coefficients that have not changed.

## Interface
- COEF_WIDTH, 13, coefficient width in bits, two's complement.
- WIN_SIZE, 3, kernel side; COEF_AMOUNT = WIN_SIZE*WIN_SIZE.
- FRAME_SYNC_EN, 1, 1: a request with `req_sync_i`=1 waits for `eof_stb_i`; 0: `req_sync_i` is ignored and writes start immediately.
- SKIP_UNCHANGED, 1, 1: a coefficient equal to its mirror value produces no strobe.

- clk_i  input  1  clock; the block has one clock.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  kernel request valid.
- req_ready_o  output  1  block idle and able to accept a request.
- req_kernel_i  input  COEF_AMOUNT*COEF_WIDTH  packed kernel; element i is coefficient i.
- req_sync_i  input  1  defer the writes to the next `eof_stb_i`.
- eof_stb_i  input  1  one-cycle pulse on the handshaked last pixel of a frame on the conv input stream.
- conv_2d_ctrl_o  conv_2d_if.master  drives `wr_stb`, `coef_num` and `coef_val`.
- busy_o  output  1  a request is held and not yet complete.
- done_o  output  1  one-cycle pulse when a request completes.

## Operation
- FSM states:
  - IDLE → WAIT_EOF, on accept when sync is effective (FRAME_SYNC_EN=1 and `req_sync_i`=1).
  - IDLE → WRITE, on accept otherwise.
  - WAIT_EOF → WRITE, on `eof_stb_i`.
  - WRITE → DONE, after index COEF_AMOUNT-1.
  - DONE → IDLE, unconditionally.
- Accept: a request is accepted when `req_valid_i && req_ready_o`. The kernel and the effective sync flag are captured into a shadow register on that cycle. `req_ready_o` = (state == IDLE).
- WRITE:
  - An index counter runs 0..COEF_AMOUNT-1, one index per cycle, including skipped indices, so WRITE always lasts exactly COEF_AMOUNT cycles.
  - Per index: `coef_num` = index and `coef_val` = the shadow coefficient, sign-extended to the interface width.
  - `wr_stb` = 1 unless SKIP_UNCHANGED=1 and the shadow value equals the mirror value.
  - The mirror entry is updated whenever a strobe is issued.
- Mirror:
  - COEF_AMOUNT×COEF_WIDTH registers, reset to 0. This matches the bridge's reset contents, since both share `rst_i`.
- Driven outputs are registered. `coef_num`/`coef_val` hold their last values outside WRITE; `wr_stb` = 0 outside WRITE.
- `eof_stb_i` is ignored outside WAIT_EOF. An EOF on the accept cycle itself does not count.
- `req_valid_i` is ignored while not IDLE. No queueing.
- Reset mid-operation: the FSM returns to IDLE and the mirror is cleared. The partially written kernel is abandoned, and the bridge is reset by the same `rst_i`.
- Reset values: `req_ready_o`=1, `busy_o`=0, `done_o`=0, `wr_stb`=0, `coef_num`=0, `coef_val`=0.

## Timing
- Accept at cycle T without sync:
  - index i is presented at T+1+i;
  - `done_o` is high at T+1+COEF_AMOUNT (DONE state);
  - `req_ready_o` returns high at T+2+COEF_AMOUNT.
- With sync and `eof_stb_i` at cycle E>T: index i is presented at E+1+i, and `done_o` is high at E+1+COEF_AMOUNT.
- `busy_o` = (state != IDLE). It is high from T+1 through the `done_o` cycle.
- The minimum request-to-request spacing is COEF_AMOUNT+2 cycles.
- Vertical blanking at the conv input must be ≥ COEF_AMOUNT cycles for a synced update to complete before the next frame. This is the integrator's responsibility and is not checked.

## Structure
- Package `conv_2d_coef_loader_pkg`:
  - state enum typedef (IDLE, WAIT_EOF, WRITE, DONE);
  - function `coef_amount(win_size)`;
  - `COEF_NUM_WIDTH` = $clog2(COEF_AMOUNT).
- One sub-module is natural: `conv_2d_coef_mirror`, holding the mirror registers plus the compare and update logic. The FSM and counter stay in the top module.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- After reset, send kernel 0..8 (value = index+1) with sync=0, accepted at T → 9 strobes at T+1..T+9 with `coef_num` 0..8, `done_o` at T+10, `req_ready_o` high at T+11; a bridge model holds 1..9.
- Resend the same kernel, except coef 4 = -3 (13'h1FFD) → exactly one strobe, `coef_num`=4, `coef_val` sign-extended -3; WRITE still lasts 9 cycles.
- Sync=1 request, then `eof_stb_i` pulsed at T (the accept cycle) and again at T+20 → `busy_o` high from T+1 with no strobes until T+21; `done_o` at T+30.
- Hold `req_valid_i` high with a different kernel during a WRITE → not accepted; it is accepted on the first IDLE cycle after `done_o`.
- Assert `rst_i` at the third strobe → the following cycle `wr_stb`=0, `req_ready_o`=1; a subsequent all-zero kernel produces 0 strobes (mirror is zero).
- Repeat the first scenario with FRAME_SYNC_EN=0 and `req_sync_i`=1, and with SKIP_UNCHANGED=0 on an identical kernel → writes start immediately in both cases; the identical kernel still yields 9 strobes.
